// File: rtl/adc_scan_arbiter_if.sv
// -----------------------------------------------------------------------------
// adc_scan_arbiter_if
// Bundles the requester side and the ADC side of the scan arbiter.
//
// Requester side : req (4, level), ack (4, one-hot pulse), result (8),
//                  result_valid (strobe), err (timeout strobe), busy
// ADC side       : ale, start, oe, addr (2) towards the ADC;
//                  eoc, adc_data (8) from the ADC
//
// Modports
//   slave  : the arbiter (samples req/eoc/adc_data, drives everything else)
//   master : the environment (requesters plus ADC)
// -----------------------------------------------------------------------------
interface adc_scan_arbiter_if;
  logic [3:0] req;
  logic [3:0] ack;
  logic [7:0] result;
  logic       result_valid;
  logic       err;
  logic       busy;
  logic       ale;
  logic       start;
  logic       oe;
  logic [1:0] addr;
  logic       eoc;
  logic [7:0] adc_data;

  modport slave (
    input  req, eoc, adc_data,
    output ack, result, result_valid, err, busy, ale, start, oe, addr
  );

  modport master (
    output req, eoc, adc_data,
    input  ack, result, result_valid, err, busy, ale, start, oe, addr
  );
endinterface

// File: rtl/adc_scan_arbiter.sv
// -----------------------------------------------------------------------------
// adc_scan_arbiter
// Shares one 4-channel ADC among four requesters. Requester i owns ADC
// channel i. Pending requests are served round-robin; each grant runs one
// full ADC handshake (address latch, start pulse, wait for EOC to fall and
// rise again, output-enable read) and completes with a one-cycle ack /
// result_valid strobe to the served requester.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : adc_scan_arbiter_if.slave (req/ack/result/result_valid/err/busy
//            towards requesters, ale/start/oe/addr/eoc/adc_data towards ADC)
//
// Parameters
//   TIMEOUT_CYCLES : EOC wait limit in clk cycles, 1..255
//
// Build option
//   ADC_SCAN_TIMEOUT_EN : when defined, the combined time spent in WAIT_LO and
//   WAIT_HI is bounded by TIMEOUT_CYCLES; on expiry the conversion completes
//   with err=1 and result=0x00. When undefined, err is constant 0 and the
//   wait states wait for EOC indefinitely.
//
// All outputs come straight from flops: each output register is loaded from
// the next-state decode, so it is high exactly while the FSM sits in the
// state that owns it.
// -----------------------------------------------------------------------------
module adc_scan_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  adc_scan_arbiter_if.slave  bus
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("adc_scan_arbiter: TIMEOUT_CYCLES must lie in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_ALE     = 3'd2,
    S_START   = 3'd3,
    S_WAIT_LO = 3'd4,
    S_WAIT_HI = 3'd5,
    S_READ    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       timeout_s;
  logic       tmo_hit_s;
  logic [1:0] ptr_r;
  logic [1:0] sel_r;
  logic [1:0] pick_s;

  logic       ale_r;
  logic       start_r;
  logic       oe_r;
  logic [1:0] addr_r;
  logic [3:0] ack_r;
  logic [7:0] result_r;
  logic       result_valid_r;
  logic       err_r;
  logic       busy_r;

  // First requester at or after ptr (ascending, wrapping 3->0) with req set.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v,
                                         input logic [1:0] ptr_v);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr_v;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_v + 2'(k);
      if (!found && req_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(bus.req, ptr_r);

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_r;

  // Wait-cycle counter: one count per cycle spent in WAIT_LO or WAIT_HI,
  // cleared in every other state so each conversion starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else if ((state_r == S_WAIT_LO) || (state_r == S_WAIT_HI)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= 8'd0;
    end
  end

  // Expiry fires on the TIMEOUT_CYCLES-th wait cycle.
  assign tmo_hit_s = ((state_r == S_WAIT_LO) || (state_r == S_WAIT_HI)) &&
                     (cnt_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. Expiry takes priority over an EOC edge seen in the
  // same cycle, so a late EOC never masks a timeout.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req != 4'b0000) begin
          state_s = S_ARB;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARB:   state_s = S_ALE;
      S_ALE:   state_s = S_START;
      S_START: state_s = S_WAIT_LO;
      S_WAIT_LO: begin
        if (tmo_hit_s) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else if (!bus.eoc) begin
          state_s = S_WAIT_HI;
        end else begin
          state_s = S_WAIT_LO;
        end
      end
      S_WAIT_HI: begin
        if (tmo_hit_s) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else if (bus.eoc) begin
          state_s = S_READ;
        end else begin
          state_s = S_WAIT_HI;
        end
      end
      S_READ:  state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Grant capture: the winner is chosen from the request vector that wakes
  // the FSM, so sel/addr are already valid during ARB and stay frozen until
  // the next grant. Later request changes cannot disturb this conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r  <= 2'd0;
      addr_r <= 2'd0;
    end else if ((state_r == S_IDLE) && (state_s == S_ARB)) begin
      sel_r  <= pick_s;
      addr_r <= pick_s;
    end else begin
      sel_r  <= sel_r;
      addr_r <= addr_r;
    end
  end

  // Round-robin pointer: the requester after the one just served gets
  // priority next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= 2'd0;
    end else if (state_r == S_DONE) begin
      ptr_r <= sel_r + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Result register: loaded at the end of READ while oe is high, forced to
  // zero on a timeout, otherwise holds its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r <= 8'h00;
    end else if (state_r == S_READ) begin
      result_r <= bus.adc_data;
    end else if (timeout_s) begin
      result_r <= 8'h00;
    end else begin
      result_r <= result_r;
    end
  end

  // Control and strobe outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ale_r          <= 1'b0;
      start_r        <= 1'b0;
      oe_r           <= 1'b0;
      ack_r          <= 4'b0000;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      ale_r          <= (state_s == S_ALE);
      start_r        <= (state_s == S_START);
      oe_r           <= (state_s == S_READ);
      ack_r          <= (state_s == S_DONE) ? (4'b0001 << sel_r) : 4'b0000;
      result_valid_r <= (state_s == S_DONE);
      err_r          <= timeout_s;
      busy_r         <= (state_s != S_IDLE);
    end
  end

  assign bus.ale          = ale_r;
  assign bus.start        = start_r;
  assign bus.oe           = oe_r;
  assign bus.addr         = addr_r;
  assign bus.ack          = ack_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.err          = err_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_arbiter
// Self-checking bench for adc_scan_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge. A small reference keeps the
// round-robin pointer as an integer and predicts each winner by scanning
// ptr, ptr+1, ... mod 4; an ADC stand-in inside the conversion task drops
// and raises eoc with chosen delays and presents the sample value.
// Build with ADC_SCAN_TIMEOUT_EN defined to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_adc_scan_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   ptr_m;

  adc_scan_arbiter_if bus_if ();

  adc_scan_arbiter #(.TIMEOUT_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner predicted from the round-robin rule.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ".ale"},   32'(bus_if.ale),          32'd0);
    chk({tag, ".start"}, 32'(bus_if.start),        32'd0);
    chk({tag, ".oe"},    32'(bus_if.oe),           32'd0);
    chk({tag, ".addr"},  32'(bus_if.addr),         32'd0);
    chk({tag, ".ack"},   32'(bus_if.ack),          32'd0);
    chk({tag, ".res"},   32'(bus_if.result),       32'd0);
    chk({tag, ".rv"},    32'(bus_if.result_valid), 32'd0);
    chk({tag, ".err"},   32'(bus_if.err),          32'd0);
    chk({tag, ".busy"},  32'(bus_if.busy),         32'd0);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus_if.req      = 4'b0000;
    bus_if.eoc      = 1'b1;
    bus_if.adc_data = 8'h00;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus_if.busy !== 1'b0) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("wait_idle_timeout", 32'(bus_if.busy), 32'd0);
  endtask

  // One full conversion: eoc falls a+1 samples after start is seen and rises
  // b+1 samples after that. With hold=0 the served bit is dropped after ack.
  task automatic conv(input logic [3:0] reqv, input int a, input int b,
                      input logic [7:0] data, input bit hold, input bit min_lat,
                      input string tag, output logic [3:0] ack_o,
                      output logic [7:0] res_o);
    int   win;
    int   cyc;
    int   ns;
    bit   started;
    bit   acked;
    logic [3:0] exp_ack;
    wait_idle();
    win        = model_pick(reqv);
    exp_ack    = 4'(1 << win);
    bus_if.req = reqv;
    cyc = 0; ns = 0; started = 1'b0; acked = 1'b0;
    ack_o = 4'b0000; res_o = 8'h00;
    while (!acked && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
      chk({tag, ".excl"}, 32'($onehot0({bus_if.ale, bus_if.start, bus_if.oe})), 32'd1);
      if (bus_if.ale === 1'b1) chk({tag, ".addr_ale"}, 32'(bus_if.addr), 32'(win));
      if (started) ns++;
      if (bus_if.start === 1'b1) begin
        started = 1'b1;
        ns = 0;
      end
      if (started && (ns == 1 + a)) begin
        bus_if.eoc      = 1'b0;
        bus_if.adc_data = data;
      end
      if (started && (ns == 2 + a + b)) bus_if.eoc = 1'b1;
      if (bus_if.ack !== 4'b0000) begin
        acked = 1'b1;
        ack_o = bus_if.ack;
        res_o = bus_if.result;
        chk({tag, ".ack"},  32'(bus_if.ack),          32'(exp_ack));
        chk({tag, ".res"},  32'(bus_if.result),       32'(data));
        chk({tag, ".rv"},   32'(bus_if.result_valid), 32'd1);
        chk({tag, ".err"},  32'(bus_if.err),          32'd0);
        chk({tag, ".addr"}, 32'(bus_if.addr),         32'(win));
        if (min_lat) chk({tag, ".latency"}, 32'(cyc), 32'd7);
      end else begin
        chk({tag, ".rv_low"}, 32'(bus_if.result_valid), 32'd0);
      end
    end
    if (!acked) chk({tag, ".no_ack"}, 32'(acked), 32'd1);
    ptr_m           = (win + 1) % 4;
    bus_if.req      = hold ? reqv : (reqv & ~exp_ack);
    bus_if.adc_data = 8'($urandom);
    @(negedge clk);
    chk({tag, ".res_hold"}, 32'(bus_if.result),       32'(data));
    chk({tag, ".ack_once"}, 32'(bus_if.ack),          32'd0);
    chk({tag, ".rv_once"},  32'(bus_if.result_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] ack_v;
    logic [7:0] res_v;
    logic [3:0] seq [5];
    int         ns;
    int         acks;
    n_cmp = 0;
    n_bad = 0;
    ptr_m = 0;
    reset = 1'b1;
    bus_if.req = 4'b0000; bus_if.eoc = 1'b1; bus_if.adc_data = 8'h00;
    @(negedge clk);

    // Reset state, then single request on channel 2 at minimum latency.
    do_reset();
    conv(4'b0100, 0, 0, 8'hA5, 1'b0, 1'b1, "single2", ack_v, res_v);
    chk("single2.ack_const", 32'(ack_v), 32'h4);
    chk("single2.res_const", 32'(res_v), 32'hA5);

    // After channel 2, channel 0 must precede channel 2.
    conv(4'b0101, 1, 2, 8'h5A, 1'b0, 1'b0, "rr0101a", ack_v, res_v);
    chk("rr0101a.const", 32'(ack_v), 32'h1);
    conv(4'b0101, 0, 1, 8'hC3, 1'b0, 1'b0, "rr0101b", ack_v, res_v);
    chk("rr0101b.const", 32'(ack_v), 32'h4);

    // All four held continuously from a fresh reset.
    do_reset();
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      conv(4'b1111, 0, 0, 8'(8'h10 + i), 1'b1, 1'b1, "all4", ack_v, res_v);
      chk("all4.seq", 32'(ack_v), 32'(seq[i]));
    end
    bus_if.req = 4'b0000;

    // Randomized request vectors, EOC delays and samples.
    for (int i = 0; i < 16; i++) begin
      conv(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand", ack_v, res_v);
    end
    bus_if.req = 4'b0000;

    // Reset during WAIT_HI abandons the conversion; pointer returns to 0.
    wait_idle();
    ptr_m = 1;
    conv(4'b0010, 0, 0, 8'h77, 1'b0, 1'b0, "pre_abort", ack_v, res_v);
    wait_idle();
    bus_if.req = 4'b0100;
    ns = -1;
    for (int c = 0; c < 20 && ns < 2; c++) begin
      @(negedge clk);
      if (ns >= 0) ns++;
      if (bus_if.start === 1'b1) ns = 0;
      if (ns == 1) bus_if.eoc = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    bus_if.req = 4'b0000;
    bus_if.eoc = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.no_ack", 32'(bus_if.ack), 32'd0);
    end
    conv(4'b1010, 0, 0, 8'h3C, 1'b0, 1'b1, "post_abort_1010", ack_v, res_v);
    chk("post_abort_1010.const", 32'(ack_v), 32'h2);
    conv(4'b1000, 0, 0, 8'h96, 1'b0, 1'b1, "post_abort_1000", ack_v, res_v);
    chk("post_abort_1000.const", 32'(ack_v), 32'h8);

    // EOC stuck high.
    wait_idle();
    bus_if.req = 4'b0001;
    bus_if.eoc = 1'b1;
    acks = 0;
`ifdef ADC_SCAN_TIMEOUT_EN
    ns = 0;
    while ((bus_if.ack === 4'b0000) && (ns < 100)) begin
      @(negedge clk);
      ns++;
    end
    chk("tmo.latency", 32'(ns), 32'd14);
    chk("tmo.ack", 32'(bus_if.ack), 32'h1);
    chk("tmo.err", 32'(bus_if.err), 32'd1);
    chk("tmo.res", 32'(bus_if.result), 32'd0);
    chk("tmo.rv", 32'(bus_if.result_valid), 32'd1);
    bus_if.req = 4'b0000;
    @(negedge clk);
    chk("tmo.idle", 32'(bus_if.busy), 32'd0);
    chk("tmo.err_once", 32'(bus_if.err), 32'd0);
`else
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus_if.ack !== 4'b0000) acks++;
      if (bus_if.err !== 1'b0) acks++;
    end
    chk("stuck.busy", 32'(bus_if.busy), 32'd1);
    chk("stuck.no_ack_err", 32'(acks), 32'd0);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
